// File: rtl/printer_port.sv
// MSX Centronics printer port (I/O 90h-97h): data latch, min-width strobe with data hold, busy readback; `PRINTER_ACK_EN adds ACK wait.
// Latency: strobe write -> pin low 2 edges, read data 1 edge, busy pin -> d_to_cpu 3 edges; no backpressure, CPU polls busy.
module printer_port #(
    parameter int STROBE_MIN  = 32,
    parameter int HOLD_CYCLES = 16,
    parameter int ACK_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cen_n,
    input  logic       addr0,
    input  logic       wr_n,
    input  logic       rd_n,
    input  logic [7:0] d_from_cpu,
    output logic [7:0] d_to_cpu,
    output logic [7:0] prn_data,
    output logic       prn_strobe_n,
    input  logic       prn_busy,
    input  logic       prn_ack_n
);
    localparam int CNT_MAX_SH = (STROBE_MIN > HOLD_CYCLES) ? STROBE_MIN : HOLD_CYCLES;
    localparam int CNT_MAX    = (ACK_TIMEOUT > CNT_MAX_SH) ? ACK_TIMEOUT : CNT_MAX_SH;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STROBE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
`ifdef PRINTER_ACK_EN
    localparam logic [1:0] S_WAIT_ACK = 2'd3;
`endif

    logic             w_wr_act;
    logic             w_wp;
    logic             w_cnt_zero;
    logic             w_busy_st;
    logic             r_wr_act_q;
    logic [7:0]       r_data_latch;
    logic             r_strobe_req;
    logic             r_busy_m;
    logic             r_busy_s;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_strobe_n;
    logic [7:0]       r_prn_data;
    logic [7:0]       r_d_to_cpu;

    // One register update per access, however long wr_n stays low.
    assign w_wr_act = ~cen_n & ~wr_n;
    assign w_wp     = w_wr_act & ~r_wr_act_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_act_q   <= 1'b0;
            r_data_latch <= 8'h00;
            r_strobe_req <= 1'b0;
        end else begin
            r_wr_act_q <= w_wr_act;
            if (w_wp) begin
                if (addr0)
                    r_data_latch <= d_from_cpu;
                else
                    r_strobe_req <= ~d_from_cpu[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy_m <= 1'b0;
            r_busy_s <= 1'b0;
        end else begin
            r_busy_m <= prn_busy;
            r_busy_s <= r_busy_m;
        end
    end

`ifdef PRINTER_ACK_EN
    logic r_ack_m;
    logic r_ack_s;
    logic r_ack_s_q;
    logic w_ack_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack_m   <= 1'b1;
            r_ack_s   <= 1'b1;
            r_ack_s_q <= 1'b1;
        end else begin
            r_ack_m   <= prn_ack_n;
            r_ack_s   <= r_ack_m;
            r_ack_s_q <= r_ack_s;
        end
    end

    assign w_ack_fall = r_ack_s_q & ~r_ack_s;
`else
    logic w_unused;
    assign w_unused = prn_ack_n;
`endif

    assign w_cnt_zero = (r_cnt == '0);

    // Strobe pin is registered so state decode glitches never reach the printer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_strobe_n <= 1'b1;
            r_prn_data <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_prn_data <= r_data_latch;
                    if (r_strobe_req) begin
                        r_cnt      <= CNT_W'(STROBE_MIN - 1);
                        r_strobe_n <= 1'b0;
                        r_state    <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (!r_strobe_req) begin
                        r_cnt      <= CNT_W'(HOLD_CYCLES - 1);
                        r_strobe_n <= 1'b1;
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
`ifdef PRINTER_ACK_EN
                        r_cnt   <= CNT_W'(ACK_TIMEOUT);
                        r_state <= S_WAIT_ACK;
`else
                        r_state <= S_IDLE;
`endif
                    end
                end
`ifdef PRINTER_ACK_EN
                S_WAIT_ACK: begin
                    if (w_ack_fall || w_cnt_zero)
                        r_state <= S_IDLE;
                    else
                        r_cnt <= r_cnt - CNT_W'(1);
                end
`endif
                default: begin
                    r_state    <= S_IDLE;
                    r_strobe_n <= 1'b1;
                end
            endcase
        end
    end

    assign w_busy_st = r_busy_s | (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset)
            r_d_to_cpu <= 8'hFF;
        else if (~cen_n & ~rd_n)
            r_d_to_cpu <= addr0 ? 8'hFF : {6'b111111, w_busy_st, 1'b1};
        else
            r_d_to_cpu <= 8'hFF;
    end

    assign d_to_cpu     = r_d_to_cpu;
    assign prn_data     = r_prn_data;
    assign prn_strobe_n = r_strobe_n;
endmodule

// File: tb/tb_printer_port.sv
// Self-checking bench for printer_port: strobe pulses scored against an expected-pulse queue, status reads checked inline.
`timescale 1ns/1ps
module tb_printer_port;
    localparam int STROBE_MIN  = 32;
    localparam int HOLD_CYCLES = 16;
    localparam int ACK_TIMEOUT = 100;
    // Edges from strobe release to first FDh read: HOLD, (ack timeout wait), plus one for the read register.
    // The same count separates strobe release from a queued re-strobe (one IDLE cycle).
`ifdef PRINTER_ACK_EN
    localparam int IDLE_AFTER_RISE = HOLD_CYCLES + ACK_TIMEOUT + 2;
`else
    localparam int IDLE_AFTER_RISE = HOLD_CYCLES + 1;
`endif

    typedef struct {
        logic [7:0] dat;
        int         width;
    } pulse_t;

    logic       clk;
    logic       reset;
    logic       cen_n;
    logic       addr0;
    logic       wr_n;
    logic       rd_n;
    logic [7:0] d_from_cpu;
    logic [7:0] d_to_cpu;
    logic [7:0] prn_data;
    logic       prn_strobe_n;
    logic       prn_busy;
    logic       prn_ack_n;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc_n = 0;
    int     last_rise_cyc = -1;
    int     last_fall_cyc = -1;
    pulse_t exp_q[$];
    bit         in_pulse = 0;
    int         low_cnt = 0;
    logic [7:0] pulse_dat = 8'h00;

    printer_port #(
        .STROBE_MIN (STROBE_MIN),
        .HOLD_CYCLES(HOLD_CYCLES),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cen_n       (cen_n),
        .addr0       (addr0),
        .wr_n        (wr_n),
        .rd_n        (rd_n),
        .d_from_cpu  (d_from_cpu),
        .d_to_cpu    (d_to_cpu),
        .prn_data    (prn_data),
        .prn_strobe_n(prn_strobe_n),
        .prn_busy    (prn_busy),
        .prn_ack_n   (prn_ack_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Pulse monitor: measures each strobe-low width and pops the expected pulse at release.
    always @(negedge clk) begin
        pulse_t e;
        if (reset) begin
            in_pulse = 0;
        end else if (!prn_strobe_n) begin
            if (!in_pulse) begin
                in_pulse      = 1;
                low_cnt       = 0;
                pulse_dat     = prn_data;
                last_fall_cyc = cyc_n;
            end
            low_cnt++;
        end else if (in_pulse) begin
            in_pulse      = 0;
            last_rise_cyc = cyc_n;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pulse_unexpected: width %0d data %h, required no pulse", low_cnt, pulse_dat);
            end else begin
                e = exp_q.pop_front();
                if (low_cnt !== e.width || pulse_dat !== e.dat || prn_data !== e.dat) begin
                    n_bad++;
                    $display("FAIL pulse: width %0d data %h/%h, required width %0d data %h",
                             low_cnt, pulse_dat, prn_data, e.width, e.dat);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    function automatic pulse_t mk(input logic [7:0] d, input int w);
        pulse_t p;
        p.dat   = d;
        p.width = w;
        return p;
    endfunction

    // Request-to-release spacing in clocks gives the CPU-driven width; STROBE_MIN is the floor.
    function automatic int exp_width(input int req_clocks);
        return (req_clocks > STROBE_MIN) ? req_clocks : STROBE_MIN;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic io_write(input logic a, input logic [7:0] d, input int len, input logic [7:0] d_later);
        cen_n      = 1'b0;
        wr_n       = 1'b0;
        addr0      = a;
        d_from_cpu = d;
        cyc();
        d_from_cpu = d_later;
        repeat (len - 1) cyc();
        cen_n = 1'b1;
        wr_n  = 1'b1;
        cyc();
    endtask

    // Polls status until idle; checks the hold-phase status/data and the release-to-idle distance.
    task automatic measure_hold(input string nm, input logic [7:0] hold_dat, input bit toggle_ack);
        bit seen_idle = 0;
        int t_idle = 0;
        cen_n = 1'b0;
        rd_n  = 1'b0;
        addr0 = 1'b0;
        for (int i = 0; i < 1000 && !seen_idle; i++) begin
            cyc();
            if (toggle_ack) prn_ack_n = ~prn_ack_n;
            if (last_rise_cyc >= 0 && cyc_n == last_rise_cyc + 2) begin
                n_cmp++;
                if (d_to_cpu !== 8'hFF || prn_data !== hold_dat) begin
                    n_bad++;
                    $display("FAIL %s_hold: status %h data %h, required FF %h", nm, d_to_cpu, prn_data, hold_dat);
                end
            end
            if (d_to_cpu === 8'hFD) begin
                seen_idle = 1;
                t_idle    = cyc_n;
            end
        end
        n_cmp++;
        if (!seen_idle || last_rise_cyc < 0) begin
            n_bad++;
            $display("FAIL %s_idle: timeout (rise %0d), required idle status", nm, last_rise_cyc);
        end else if (t_idle - last_rise_cyc != IDLE_AFTER_RISE) begin
            n_bad++;
            $display("FAIL %s_idle: %0d edges to idle, required %0d", nm, t_idle - last_rise_cyc, IDLE_AFTER_RISE);
        end
        cen_n     = 1'b1;
        rd_n      = 1'b1;
        prn_ack_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        repeat (3) cyc();
        n_cmp++;
        if (prn_strobe_n !== 1'b1 || prn_data !== 8'h00 || d_to_cpu !== 8'hFF) begin
            n_bad++;
            $display("FAIL rst_init: strobe %b data %h rd %h, required 1 00 FF", prn_strobe_n, prn_data, d_to_cpu);
        end
        reset = 1'b0;
        cyc();
        io_write(1'b1, 8'h5A, 1, 8'h5A);
        io_write(1'b0, 8'h00, 2, 8'h00);
        repeat (3) cyc();
        n_cmp++;
        if (prn_strobe_n !== 1'b0 || prn_data !== 8'h5A) begin
            n_bad++;
            $display("FAIL rst_pre: strobe %b data %h, required 0 5A", prn_strobe_n, prn_data);
        end
        cen_n = 1'b0;
        rd_n  = 1'b0;
        reset = 1'b1;
        cyc();
        n_cmp++;
        if (prn_strobe_n !== 1'b1 || prn_data !== 8'h00 || d_to_cpu !== 8'hFF) begin
            n_bad++;
            $display("FAIL rst_mid: strobe %b data %h rd %h, required 1 00 FF", prn_strobe_n, prn_data, d_to_cpu);
        end
        cyc();
        reset = 1'b0;
        cen_n = 1'b1;
        rd_n  = 1'b1;
        repeat (4) cyc();
        n_cmp++;
        if (prn_strobe_n !== 1'b1 || prn_data !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_after: strobe %b data %h, required 1 00", prn_strobe_n, prn_data);
        end
    endtask

    task automatic test_single_pulse();
        io_write(1'b1, 8'hA5, 10, 8'h11);
        repeat (2) cyc();
        n_cmp++;
        if (prn_data !== 8'hA5) begin
            n_bad++;
            $display("FAIL one_update: data %h, required A5", prn_data);
        end
        last_rise_cyc = -1;
        exp_q.push_back(mk(8'hA5, exp_width(4)));
        io_write(1'b0, 8'h00, 3, 8'h00);
        io_write(1'b0, 8'hFF, 1, 8'hFF);
        measure_hold("single", 8'hA5, 1'b0);
    endtask

    task automatic test_extend();
        last_rise_cyc = -1;
        exp_q.push_back(mk(8'hA5, exp_width(51)));
        io_write(1'b0, 8'h00, 50, 8'h00);
        io_write(1'b0, 8'h01, 1, 8'h01);
        measure_hold("extend", 8'hA5, 1'b0);
    endtask

    task automatic test_data_mid_strobe();
        last_rise_cyc = -1;
        exp_q.push_back(mk(8'hA5, exp_width(6)));
        io_write(1'b0, 8'hFE, 3, 8'hFE);
        io_write(1'b1, 8'h3C, 1, 8'h3C);
        io_write(1'b0, 8'hFF, 1, 8'hFF);
        measure_hold("mid", 8'hA5, 1'b0);
        n_cmp++;
        if (prn_data !== 8'h3C) begin
            n_bad++;
            $display("FAIL data_at_idle: data %h, required 3C", prn_data);
        end
    endtask

    task automatic test_back_to_back();
        int r1;
        last_rise_cyc = -1;
        exp_q.push_back(mk(8'h3C, STROBE_MIN));
        io_write(1'b0, 8'h00, 2, 8'h00);
        io_write(1'b0, 8'hFF, 1, 8'hFF);
        for (int i = 0; i < 100 && last_rise_cyc < 0; i++) cyc();
        if (last_rise_cyc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL b2b_rise: no strobe release, required release");
        end
        r1 = last_rise_cyc;
        cyc();
        last_fall_cyc = -1;
        last_rise_cyc = -1;
        exp_q.push_back(mk(8'h3C, STROBE_MIN));
        io_write(1'b0, 8'h00, 1, 8'h00);
        for (int i = 0; i < 300 && last_fall_cyc < 0; i++) cyc();
        n_cmp++;
        if (last_fall_cyc < 0) begin
            n_bad++;
            $display("FAIL b2b_gap: no second strobe, required gap %0d", IDLE_AFTER_RISE);
        end else if (last_fall_cyc - r1 != IDLE_AFTER_RISE) begin
            n_bad++;
            $display("FAIL b2b_gap: gap %0d, required %0d", last_fall_cyc - r1, IDLE_AFTER_RISE);
        end
        io_write(1'b0, 8'hFF, 1, 8'hFF);
        measure_hold("b2b", 8'h3C, 1'b0);
    endtask

    task automatic test_busy();
        cen_n    = 1'b0;
        rd_n     = 1'b0;
        addr0    = 1'b0;
        prn_busy = 1'b0;
        repeat (2) cyc();
        n_cmp++;
        if (d_to_cpu !== 8'hFD) begin n_bad++; $display("FAIL rd_idle: %h, required FD", d_to_cpu); end
        prn_busy = 1'b1;
        repeat (2) cyc();
        n_cmp++;
        if (d_to_cpu !== 8'hFD) begin n_bad++; $display("FAIL busy_lat2: %h, required FD", d_to_cpu); end
        cyc();
        n_cmp++;
        if (d_to_cpu !== 8'hFF) begin n_bad++; $display("FAIL busy_lat3: %h, required FF", d_to_cpu); end
        prn_busy = 1'b0;
        repeat (3) cyc();
        n_cmp++;
        if (d_to_cpu !== 8'hFD) begin n_bad++; $display("FAIL busy_clr: %h, required FD", d_to_cpu); end
        addr0 = 1'b1;
        cyc();
        n_cmp++;
        if (d_to_cpu !== 8'hFF) begin n_bad++; $display("FAIL rd_91h: %h, required FF", d_to_cpu); end
        addr0 = 1'b0;
        rd_n  = 1'b1;
        cyc();
        n_cmp++;
        if (d_to_cpu !== 8'hFF) begin n_bad++; $display("FAIL no_rd: %h, required FF", d_to_cpu); end
        cen_n = 1'b1;
        rd_n  = 1'b0;
        cyc();
        n_cmp++;
        if (d_to_cpu !== 8'hFF) begin n_bad++; $display("FAIL no_cs: %h, required FF", d_to_cpu); end
        rd_n = 1'b1;
        cyc();
    endtask

    task automatic test_ack();
`ifdef PRINTER_ACK_EN
        bit seen = 0;
        int t0;
        int t_idle = 0;
        last_rise_cyc = -1;
        exp_q.push_back(mk(8'h3C, STROBE_MIN));
        io_write(1'b0, 8'h00, 2, 8'h00);
        io_write(1'b0, 8'hFF, 1, 8'hFF);
        cen_n = 1'b0;
        rd_n  = 1'b0;
        addr0 = 1'b0;
        for (int i = 0; i < 200 && !(last_rise_cyc >= 0 && cyc_n >= last_rise_cyc + HOLD_CYCLES + 20); i++) cyc();
        n_cmp++;
        if (d_to_cpu !== 8'hFF) begin n_bad++; $display("FAIL ack_wait_busy: %h, required FF", d_to_cpu); end
        prn_ack_n = 1'b0;
        t0 = cyc_n;
        for (int i = 0; i < 50 && !seen; i++) begin
            cyc();
            if (d_to_cpu === 8'hFD) begin
                seen   = 1;
                t_idle = cyc_n;
            end
        end
        prn_ack_n = 1'b1;
        // IDLE three edges after the ack pin falls, status read one edge later.
        n_cmp++;
        if (!seen || t_idle - t0 != 4) begin
            n_bad++;
            $display("FAIL ack_exit: seen %0d after %0d edges, required 4", seen, t_idle - t0);
        end
        cen_n = 1'b1;
        rd_n  = 1'b1;
        cyc();
`else
        last_rise_cyc = -1;
        exp_q.push_back(mk(8'h3C, STROBE_MIN));
        io_write(1'b0, 8'h00, 2, 8'h00);
        io_write(1'b0, 8'hFF, 1, 8'hFF);
        measure_hold("ack_ignored", 8'h3C, 1'b1);
`endif
    endtask

    initial begin
        reset      = 1'b1;
        cen_n      = 1'b1;
        wr_n       = 1'b1;
        rd_n       = 1'b1;
        addr0      = 1'b0;
        d_from_cpu = 8'h00;
        prn_busy   = 1'b0;
        prn_ack_n  = 1'b1;
        test_reset();
        test_single_pulse();
        test_extend();
        test_data_mid_strobe();
        test_back_to_back();
        test_busy();
        test_ack();
        repeat (5) cyc();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d pulses pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
